address_register_bank: RTL and testbench

Parametrised address register file: NUM_REGS address registers of WIDTH bits, each with a function-select operation, two registered read ports, and dedicated stack push/pop on one register with overflow and underflow detection. It generalises the fixed three-register PC/SP/AR file. It sits between the instruction decoder and the memory address path. Index 0 is PC, SP_INDEX is SP, and the remaining registers are general address registers.

---
 rtl/address_register_bank.sv | 126 ++++++++++++
 tb/tb_address_register_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/address_register_bank.sv
// Address register file (PC, SP, general ARs) with function-select writes, stack push/pop and two read ports.
// Latency: writes and read ports take one edge; sp_empty is combinational. No backpressure: every edge is accepted.
module address_register_bank #(
    parameter int               WIDTH    = 16,
    parameter int               NUM_REGS = 3,
    parameter int               SP_INDEX = 1,
    parameter logic [WIDTH-1:0] SP_RESET = '1,
    parameter logic [WIDTH-1:0] SP_LIMIT = '0,
    parameter bit               BYPASS   = 1'b0,
    parameter int               SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    i,
    input  logic [NUM_REGS-1:0] reg_sel,
    input  logic [2:0]          fun_sel,
    input  logic                push,
    input  logic                pop,
    input  logic                clear_flags,
    input  logic [SEL_W-1:0]    out_c_sel,
    input  logic [SEL_W-1:0]    out_d_sel,
    output logic [WIDTH-1:0]    out_c,
    output logic [WIDTH-1:0]    out_d,
    output logic [NUM_REGS-1:0] wrap,
    output logic                stack_ovf,
    output logic                stack_unf,
    output logic                sp_empty
);

    localparam int HW = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wrap_q, wrap_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [WIDTH-1:0]    out_c_q, out_c_d;
    logic [WIDTH-1:0]    out_d_q, out_d_d;
    logic [WIDTH-1:0]    sp_cur;
    logic                stack_op;

    assign sp_cur   = regs_q[SP_INDEX];
    assign stack_op = push | pop;

    always_comb begin
        ovf_d   = ovf_q & ~clear_flags;
        unf_d   = unf_q & ~clear_flags;
        out_c_d = '0;
        out_d_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
            wrap_d[k] = 1'b0;
            // A stack operation takes SP away from the function-select path.
            if (reg_sel[k] && !(k == SP_INDEX && stack_op)) begin
                case (fun_sel)
                    3'b001: regs_d[k] = '0;
                    3'b010: regs_d[k] = i;
                    3'b011: begin
                        regs_d[k] = regs_q[k] + ONE;
                        wrap_d[k] = &regs_q[k];
                    end
                    3'b100: begin
                        regs_d[k] = regs_q[k] - ONE;
                        wrap_d[k] = ~|regs_q[k];
                    end
                    3'b101: regs_d[k][HW-1:0]     = i[HW-1:0];
                    3'b110: regs_d[k][WIDTH-1:HW] = i[HW-1:0];
                    default: regs_d[k] = regs_q[k];
                endcase
            end
        end

        if (push && !pop) begin
            if (sp_cur == SP_LIMIT) begin
                ovf_d = 1'b1;
            end else begin
                regs_d[SP_INDEX] = sp_cur - ONE;
                wrap_d[SP_INDEX] = ~|sp_cur;
            end
        end else if (pop && !push) begin
            if (sp_cur == SP_RESET) begin
                unf_d = 1'b1;
            end else begin
                regs_d[SP_INDEX] = sp_cur + ONE;
                wrap_d[SP_INDEX] = &sp_cur;
            end
        end

        // Out-of-range selects match no index and so read as zero.
        for (int k = 0; k < NUM_REGS; k++) begin
            if (int'(out_c_sel) == k) out_c_d = BYPASS ? regs_d[k] : regs_q[k];
            if (int'(out_d_sel) == k) out_d_d = BYPASS ? regs_d[k] : regs_q[k];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= (k == SP_INDEX) ? SP_RESET : '0;
            end
            wrap_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            out_c_q <= '0;
            out_d_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            out_c_q <= out_c_d;
            out_d_q <= out_d_d;
        end
    end

    assign out_c     = out_c_q;
    assign out_d     = out_d_q;
    assign wrap      = wrap_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
    assign sp_empty  = (sp_cur == SP_RESET);

endmodule

// File: tb/tb_address_register_bank.sv
// Table-driven bench: two banks (no bypass / bypass) share stimulus, SP_LIMIT = FFFD.
module tb_address_register_bank;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] i;
    logic [2:0]  reg_sel, fun_sel;
    logic        push, pop, clear_flags;
    logic [1:0]  out_c_sel, out_d_sel;

    logic [15:0] c0, d0, c1, d1;
    logic [2:0]  wr0, wr1;
    logic        ovf0, ovf1, unf0, unf1, emp0, emp1;

    int n_cmp = 0;
    int n_err = 0;
    int vi    = 0;

    always #5 clock = ~clock;

    address_register_bank #(.WIDTH(16), .NUM_REGS(3), .SP_INDEX(1), .SP_RESET(16'hFFFF),
                            .SP_LIMIT(16'hFFFD), .BYPASS(1'b0)) u_nobyp (
        .clock(clock), .reset_n(reset_n), .i(i), .reg_sel(reg_sel), .fun_sel(fun_sel),
        .push(push), .pop(pop), .clear_flags(clear_flags),
        .out_c_sel(out_c_sel), .out_d_sel(out_d_sel),
        .out_c(c0), .out_d(d0), .wrap(wr0), .stack_ovf(ovf0), .stack_unf(unf0), .sp_empty(emp0)
    );

    address_register_bank #(.WIDTH(16), .NUM_REGS(3), .SP_INDEX(1), .SP_RESET(16'hFFFF),
                            .SP_LIMIT(16'hFFFD), .BYPASS(1'b1)) u_byp (
        .clock(clock), .reset_n(reset_n), .i(i), .reg_sel(reg_sel), .fun_sel(fun_sel),
        .push(push), .pop(pop), .clear_flags(clear_flags),
        .out_c_sel(out_c_sel), .out_d_sel(out_d_sel),
        .out_c(c1), .out_d(d1), .wrap(wr1), .stack_ovf(ovf1), .stack_unf(unf1), .sp_empty(emp1)
    );

    typedef struct {
        logic [2:0]  rs;
        logic [2:0]  fs;
        logic [15:0] din;
        logic        psh, pp, clr;
        logic [1:0]  cs, ds;
        logic [15:0] c1, d1, c0, d0;
        logic [2:0]  wr;
        logic        ovf, unf, emp;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] fs, input logic [15:0] din,
                                input logic psh, input logic pp, input logic clr,
                                input logic [1:0] cs, input logic [1:0] ds,
                                input logic [15:0] ec1, input logic [15:0] ed1,
                                input logic [15:0] ec0, input logic [15:0] ed0,
                                input logic [2:0] wr, input logic ovf, input logic unf, input logic emp);
        vec_t v;
        v.rs = rs; v.fs = fs; v.din = din; v.psh = psh; v.pp = pp; v.clr = clr;
        v.cs = cs; v.ds = ds; v.c1 = ec1; v.d1 = ed1; v.c0 = ec0; v.d0 = ed0;
        v.wr = wr; v.ovf = ovf; v.unf = unf; v.emp = emp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, vi, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] rs, input logic [2:0] fs, input logic [15:0] din,
                         input logic psh, input logic pp, input logic clr,
                         input logic [1:0] cs, input logic [1:0] ds);
        reg_sel = rs; fun_sel = fs; i = din; push = psh; pop = pp; clear_flags = clr;
        out_c_sel = cs; out_d_sel = ds;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_state;
        chk("rst out_c nobyp", c0, 16'h0000);
        chk("rst out_d nobyp", d0, 16'h0000);
        chk("rst out_c byp",   c1, 16'h0000);
        chk("rst out_d byp",   d1, 16'h0000);
        chk("rst wrap",  {13'd0, wr0 | wr1}, 16'h0000);
        chk("rst ovf",   {15'd0, ovf0 | ovf1}, 16'h0000);
        chk("rst unf",   {15'd0, unf0 | unf1}, 16'h0000);
        chk("rst empty", {15'd0, emp0 & emp1}, 16'h0001);
    endtask

    initial begin
        //           rs     fs     din      psh pp clr cs ds   c1       d1       c0       d0      wr    ovf unf emp
        tbl[0]  = mk(3'b001,3'b010,16'hFFFE,0,0,0,2'd0,2'd1,16'hFFFE,16'hFFFF,16'h0000,16'hFFFF,3'b000,0,0,1);
        tbl[1]  = mk(3'b001,3'b011,16'h0000,0,0,0,2'd0,2'd1,16'hFFFF,16'hFFFF,16'hFFFE,16'hFFFF,3'b000,0,0,1);
        tbl[2]  = mk(3'b001,3'b011,16'h0000,0,0,0,2'd0,2'd1,16'h0000,16'hFFFF,16'hFFFF,16'hFFFF,3'b001,0,0,1);
        tbl[3]  = mk(3'b000,3'b000,16'h0000,0,0,0,2'd0,2'd1,16'h0000,16'hFFFF,16'h0000,16'hFFFF,3'b000,0,0,1);
        tbl[4]  = mk(3'b001,3'b100,16'h0000,0,0,0,2'd0,2'd1,16'hFFFF,16'hFFFF,16'h0000,16'hFFFF,3'b001,0,0,1);
        tbl[5]  = mk(3'b100,3'b010,16'h1234,0,0,0,2'd2,2'd0,16'h1234,16'hFFFF,16'h0000,16'hFFFF,3'b000,0,0,1);
        tbl[6]  = mk(3'b100,3'b110,16'h00AB,0,0,0,2'd2,2'd0,16'hAB34,16'hFFFF,16'h1234,16'hFFFF,3'b000,0,0,1);
        tbl[7]  = mk(3'b100,3'b101,16'h00CD,0,0,0,2'd2,2'd0,16'hABCD,16'hFFFF,16'hAB34,16'hFFFF,3'b000,0,0,1);
        tbl[8]  = mk(3'b101,3'b001,16'h0000,0,0,0,2'd2,2'd0,16'h0000,16'h0000,16'hABCD,16'hFFFF,3'b000,0,0,1);
        tbl[9]  = mk(3'b000,3'b000,16'h0000,1,0,0,2'd1,2'd1,16'hFFFE,16'hFFFE,16'hFFFF,16'hFFFF,3'b000,0,0,0);
        tbl[10] = mk(3'b000,3'b000,16'h0000,1,0,0,2'd1,2'd1,16'hFFFD,16'hFFFD,16'hFFFE,16'hFFFE,3'b000,0,0,0);
        tbl[11] = mk(3'b000,3'b000,16'h0000,1,0,0,2'd1,2'd1,16'hFFFD,16'hFFFD,16'hFFFD,16'hFFFD,3'b000,1,0,0);
        tbl[12] = mk(3'b000,3'b000,16'h0000,0,1,0,2'd1,2'd1,16'hFFFE,16'hFFFE,16'hFFFD,16'hFFFD,3'b000,1,0,0);
        tbl[13] = mk(3'b000,3'b000,16'h0000,0,1,0,2'd1,2'd1,16'hFFFF,16'hFFFF,16'hFFFE,16'hFFFE,3'b000,1,0,1);
        tbl[14] = mk(3'b000,3'b000,16'h0000,0,1,0,2'd1,2'd1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'b000,1,1,1);
        tbl[15] = mk(3'b000,3'b000,16'h0000,0,0,1,2'd1,2'd1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'b000,0,0,1);
        tbl[16] = mk(3'b000,3'b000,16'h0000,1,1,0,2'd1,2'd1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'b000,0,0,1);
        tbl[17] = mk(3'b010,3'b001,16'h0000,1,0,0,2'd1,2'd1,16'hFFFE,16'hFFFE,16'hFFFF,16'hFFFF,3'b000,0,0,0);
        tbl[18] = mk(3'b000,3'b000,16'h0000,1,0,0,2'd1,2'd1,16'hFFFD,16'hFFFD,16'hFFFE,16'hFFFE,3'b000,0,0,0);
        tbl[19] = mk(3'b000,3'b000,16'h0000,1,0,1,2'd1,2'd1,16'hFFFD,16'hFFFD,16'hFFFD,16'hFFFD,3'b000,1,0,0);
        tbl[20] = mk(3'b000,3'b000,16'h0000,1,1,1,2'd1,2'd1,16'hFFFD,16'hFFFD,16'hFFFD,16'hFFFD,3'b000,0,0,0);
        tbl[21] = mk(3'b010,3'b010,16'h0000,0,0,0,2'd1,2'd1,16'h0000,16'h0000,16'hFFFD,16'hFFFD,3'b000,0,0,0);
        tbl[22] = mk(3'b000,3'b000,16'h0000,1,0,0,2'd1,2'd1,16'hFFFF,16'hFFFF,16'h0000,16'h0000,3'b010,0,0,1);
        tbl[23] = mk(3'b000,3'b000,16'h0000,0,1,0,2'd1,2'd1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,3'b000,0,1,1);
        tbl[24] = mk(3'b100,3'b010,16'hBEEF,0,0,0,2'd2,2'd2,16'hBEEF,16'hBEEF,16'h0000,16'h0000,3'b000,0,1,1);
        tbl[25] = mk(3'b000,3'b000,16'h0000,0,0,0,2'd2,2'd2,16'hBEEF,16'hBEEF,16'hBEEF,16'hBEEF,3'b000,0,1,1);
        tbl[26] = mk(3'b000,3'b000,16'h0000,0,0,0,2'd3,2'd2,16'h0000,16'hBEEF,16'h0000,16'hBEEF,3'b000,0,1,1);

        reset_n = 1'b0;
        drive(3'b000, 3'b000, 16'h0000, 0, 0, 0, 2'd0, 2'd1);
        #11;
        vi = -1;
        chk_reset_state();
        #1 reset_n = 1'b1;

        for (int n = 0; n < 27; n++) begin
            vi = n;
            drive(tbl[n].rs, tbl[n].fs, tbl[n].din, tbl[n].psh, tbl[n].pp, tbl[n].clr,
                  tbl[n].cs, tbl[n].ds);
            step();
            chk("out_c byp",   c1, tbl[n].c1);
            chk("out_d byp",   d1, tbl[n].d1);
            chk("out_c nobyp", c0, tbl[n].c0);
            chk("out_d nobyp", d0, tbl[n].d0);
            chk("wrap nobyp",  {13'd0, wr0}, {13'd0, tbl[n].wr});
            chk("wrap byp",    {13'd0, wr1}, {13'd0, tbl[n].wr});
            chk("ovf",   {14'd0, ovf0, ovf1}, {14'd0, tbl[n].ovf, tbl[n].ovf});
            chk("unf",   {14'd0, unf0, unf1}, {14'd0, tbl[n].unf, tbl[n].unf});
            chk("empty", {14'd0, emp0, emp1}, {14'd0, tbl[n].emp, tbl[n].emp});
        end

        // Mid-cycle reset with a PC load pending: outputs clear at once and the load is lost.
        vi = 100;
        drive(3'b001, 3'b010, 16'h1111, 0, 0, 0, 2'd0, 2'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_state();
        @(posedge clock);
        #2 reset_n = 1'b1;
        drive(3'b000, 3'b000, 16'h0000, 0, 0, 0, 2'd0, 2'd1);
        vi = 101;
        step();
        chk("post-rst PC byp",   c1, 16'h0000);
        chk("post-rst SP byp",   d1, 16'hFFFF);
        chk("post-rst PC nobyp", c0, 16'h0000);
        chk("post-rst SP nobyp", d0, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
